// File: rtl/uart_tx_sched.sv
// Buffers CPU-written bytes in a FIFO and launches them one at a time into the UART transmitter.
// Launch is one cycle after a byte is visible in the FIFO while the UART is idle; overflowing pushes are dropped.
module uart_tx_sched #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     clr,
    input  logic                     tx_idle,
    output logic [7:0]               uart_tx_data,
    output logic                     uart_tx_enable,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_IDLE
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            ovf_q, ovf_d;
    logic            irq_q, irq_d;
    logic            pop;
    logic            push_ok;
    logic            irq_set;

    assign full           = (count_q == (AW+1)'(DEPTH));
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign uart_tx_data   = data_q;
    assign uart_tx_enable = en_q;
    assign overflow       = ovf_q;
    assign irq            = irq_q;

    // Launch/handshake sequencer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        en_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && tx_idle) begin
                    pop     = 1'b1;
                    data_d  = mem_q[rd_ptr_q];
                    en_d    = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = TW'(BUSY_TIMEOUT);
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!tx_idle) begin
                    state_d = S_WAIT_IDLE;
                end else begin
                    // A UART that never reports busy is treated as done after the timeout.
                    timer_d = timer_q - TW'(1);
                    if (timer_q <= TW'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (tx_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping and sticky status
    always_comb begin
        push_ok  = push && !clr && (!full || pop);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        ovf_d    = ovf_q | (push && !clr && !push_ok);
        irq_set  = (state_q != S_IDLE) && (state_d == S_IDLE) && empty;
        irq_d    = irq_q | irq_set;
        if (push_ok) begin
            irq_d = 1'b0;
        end
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            irq_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboarded bench for uart_tx_sched: directed scenarios plus a randomized stream against a
// behavioural UART model; a negedge monitor pops expected bytes on every launch pulse.
module tb_uart_tx_sched;
    localparam int DEPTH        = 8;
    localparam int BUSY_TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic       push;
    logic [7:0] push_data;
    logic       clr;
    logic       tx_idle;
    logic [7:0] uart_tx_data;
    logic       uart_tx_enable;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       irq;

    uart_tx_sched #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .clr(clr),
        .tx_idle(tx_idle), .uart_tx_data(uart_tx_data), .uart_tx_enable(uart_tx_enable),
        .count(count), .full(full), .empty(empty), .overflow(overflow), .irq(irq)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         en_cnt = 0;
    int         en_cyc_last = 0;
    int         en_cyc_prev = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_b;
    logic       prev_en = 1'b0;
    logic       idle_at_edge = 1'b1;

    // UART model controls
    bit hold_busy  = 0;
    bit never_busy = 0;
    int busy_len   = 100;
    int busy_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        idle_at_edge = tx_idle;
    end

    // Behavioural UART: goes busy for busy_len cycles after seeing a launch pulse.
    initial begin
        tx_idle = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_busy) begin
                tx_idle = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                tx_idle = (busy_cnt == 0);
            end else if (uart_tx_enable && !never_busy) begin
                busy_cnt = busy_len;
                tx_idle  = 1'b0;
            end else begin
                tx_idle = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            last_data = 8'h00;
        end else if (uart_tx_enable) begin
            en_cnt++;
            en_cyc_prev = en_cyc_last;
            en_cyc_last = cyc;
            check("pulse_width", 32'(prev_en), 32'd0);
            check("idle_at_launch", 32'(idle_at_edge), 32'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_enable: data 0x%0h, no byte expected", uart_tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("tx_data", 32'(uart_tx_data), 32'(exp_b));
            end
            last_data = uart_tx_data;
        end else if (en_cnt > 0) begin
            check("data_stable", 32'(uart_tx_data), 32'(last_data));
        end
        prev_en = uart_tx_enable;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_en(input int target, input int budget);
        int k = 0;
        while (en_cnt < target && k < budget) begin
            step();
            k++;
        end
        check("enable_count", 32'(en_cnt), 32'(target));
    endtask

    task automatic wait_irq(input int budget);
        int k = 0;
        while (irq !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        check("irq_raised", 32'(irq), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"}, 32'(uart_tx_data), 32'h00);
        check({tag, "_enable"}, 32'(uart_tx_enable), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        int sent;
        logic [7:0] d;

        reset = 1'b0; push = 1'b0; push_data = 8'h00; clr = 1'b0;
        repeat (3) step();
        check_reset_vals("reset");
        reset = 1'b1;
        step();

        // Single byte with a long busy period
        base = en_cnt;
        busy_len = 100;
        push = 1'b1; push_data = 8'h41; exp_q.push_back(8'h41);
        step();
        push = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_no_enable_yet", 32'(uart_tx_enable), 32'd0);
        step();
        check("single_enable", 32'(uart_tx_enable), 32'd1);
        check("single_count_after_pop", 32'(count), 32'd0);
        step();
        check("single_enable_drop", 32'(uart_tx_enable), 32'd0);
        check("single_irq_while_busy", 32'(irq), 32'd0);
        k = 0;
        while (tx_idle !== 1'b1 && k < 200) begin step(); k++; end
        check("single_tx_idle_back", 32'(tx_idle), 32'd1);
        check("single_irq_before_idle_edge", 32'(irq), 32'd0);
        step();
        check("single_irq", 32'(irq), 32'd1);
        check("single_enable_count", 32'(en_cnt), 32'(base + 1));

        // Burst into a full FIFO while the UART is held busy
        base = en_cnt;
        hold_busy = 1;
        step();
        step();
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; push_data = 8'(8'h10 + i); exp_q.push_back(8'(8'h10 + i));
            step();
        end
        push = 1'b0;
        check("burst_full", 32'(full), 32'd1);
        check("burst_count", 32'(count), 32'd8);
        check("burst_no_enable", 32'(en_cnt), 32'(base));
        check("burst_irq_cleared", 32'(irq), 32'd0);
        push = 1'b1; push_data = 8'h99;
        step();
        push = 1'b0;
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_count", 32'(count), 32'd8);
        // Release the UART, then push on the same edge as the first pop
        hold_busy = 0;
        @(posedge clk); #2;
        check("release_tx_idle", 32'(tx_idle), 32'd1);
        step();
        push = 1'b1; push_data = 8'hEE; exp_q.push_back(8'hEE);
        step();
        push = 1'b0;
        check("fullpop_count", 32'(count), 32'd8);
        check("fullpop_overflow_sticky", 32'(overflow), 32'd1);
        check("fullpop_one_launch", 32'(en_cnt), 32'(base + 1));
        busy_len = 5;
        wait_en(base + DEPTH + 1, 600);
        wait_irq(100);

        // Flush during WAIT_IDLE
        base = en_cnt;
        busy_len = 30;
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(8'hC0 + i); exp_q.push_back(8'(8'hC0 + i));
            step();
        end
        push = 1'b0;
        step();
        check("flush_first_launched", 32'(en_cnt), 32'(base + 1));
        clr = 1'b1;
        exp_q.delete();
        step();
        clr = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_overflow", 32'(overflow), 32'd0);
        check("flush_irq", 32'(irq), 32'd0);
        repeat (60) step();
        check("flush_no_more_enables", 32'(en_cnt), 32'(base + 1));
        check("flush_irq_after_complete", 32'(irq), 32'd1);

        // Timeout: UART never reports busy
        base = en_cnt;
        never_busy = 1;
        push = 1'b1; push_data = 8'h55; exp_q.push_back(8'h55);
        step();
        push_data = 8'h66; exp_q.push_back(8'h66);
        step();
        push = 1'b0;
        wait_en(base + 2, 100);
        check("timeout_spacing", 32'(en_cyc_last - en_cyc_prev), 32'(1 + BUSY_TIMEOUT + 1));
        wait_irq(60);
        never_busy = 0;

        // Asynchronous reset mid-burst
        base = en_cnt;
        busy_len = 8;
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; push_data = 8'(8'h70 + i); exp_q.push_back(8'(8'h70 + i));
            step();
        end
        push = 1'b0;
        wait_en(base + 2, 100);
        @(posedge clk); #3;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals("midreset");
        step();
        step();
        reset = 1'b1;
        k = 0;
        while (tx_idle !== 1'b1 && k < 50) begin step(); k++; end
        base = en_cnt;
        push = 1'b1; push_data = 8'hA5; exp_q.push_back(8'hA5);
        step();
        push = 1'b0;
        wait_en(base + 1, 20);
        wait_irq(40);

        // Randomized stream with random UART busy times
        base = en_cnt;
        sent = 0;
        k = 0;
        while (sent < 40 && k < 3000) begin
            busy_len = $urandom_range(1, 6);
            if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
                d = 8'($urandom);
                push = 1'b1; push_data = d; exp_q.push_back(d);
                sent++;
            end else begin
                push = 1'b0;
            end
            step();
            k++;
        end
        push = 1'b0;
        check("random_all_pushed", 32'(sent), 32'd40);
        wait_en(base + sent, 2000);
        wait_irq(100);
        check("random_final_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
